id_hazard_ctrl: RTL and testbench

Pipeline interlock controller for the five-stage MIPS core. It sits beside the ID stage and keeps a shadow record of the destination register, write-enable and load flag for the instructions in EX, MEM and WB. From that record it produces the hazard flags and forward selects consumed by ID. It also generates stall, bubble and flush controls, freezes the pipe on cache misses, and drains the pipe on a halt before asserting `halted_o`.

---
 rtl/id_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// Pipeline interlock controller for the ID stage. It keeps a shadow copy of the
// EX/MEM/WB destinations and derives forwarding, load-use stalls, cache freezes and halt drain.
module id_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             reg1_num,
  input  logic [4:0]             reg2_num,
  input  logic                   is_reg1_valid,
  input  logic                   is_reg2_valid,
  input  logic                   is_SW_SB,
  input  logic [4:0]             dest_reg_num,
  input  logic                   reg_write,
  input  logic                   mem_to_reg,
  input  logic                   halt_dec,
  input  logic                   branch_taken,
  input  logic                   mem_cache_en,
  input  logic                   cache_ready,
  output logic                   stall_if_id,
  output logic                   bubble_ex,
  output logic                   freeze_all,
  output logic                   flush_if,
  output logic                   has_reg1_hazard,
  output logic                   has_reg2_hazard,
  output logic                   has_saved_val_hazard,
  output logic [1:0]             fwd1_sel,
  output logic [1:0]             fwd2_sel,
  output logic [1:0]             fwd_sv_sel,
  output logic                   halted_o,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } shadow_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  shadow_t [2:0]          shadow_q, shadow_d;
  state_t                 state_q, state_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic                   halted_q, halted_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [2:0]      src_ok;
  logic [2:0][4:0] op_num;
  logic [2:0]      op_use;
  logic [2:0]      op_lhit;
  logic [1:0]      op_sel [3];
  logic            luse;
  logic            mem_stall;
  logic            issue;
  logic            unused_wb_ld;

  // The WB load flag is kept for a complete record but nothing downstream needs it.
  assign unused_wb_ld = shadow_q[WB].ld;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      assign src_ok[gi] = shadow_q[gi].v && shadow_q[gi].wr && (shadow_q[gi].dest != 5'd0);
    end
  endgenerate

  // Operand 0 is rs, 1 is rt as an ALU source, 2 is rt as store data.
  assign op_num    = {reg2_num, reg2_num, reg1_num};
  assign op_use[0] = id_valid && is_reg1_valid;
  assign op_use[1] = id_valid && is_reg2_valid && !is_SW_SB;
  assign op_use[2] = id_valid && is_SW_SB;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_op
      logic [2:0] hit;
      for (gj = 0; gj < 3; gj++) begin : g_stage
        assign hit[gj] = src_ok[gj] && (shadow_q[gj].dest == op_num[gi]);
      end
      // A loading EX producer blocks the operand instead of forwarding it.
      assign op_lhit[gi] = op_use[gi] && hit[EX] && shadow_q[EX].ld;
      assign op_sel[gi]  = !op_use[gi]            ? 2'b00 :
                           hit[EX]                ? (shadow_q[EX].ld ? 2'b00 : 2'b01) :
                           hit[MEM]               ? 2'b10 :
                           hit[WB]                ? 2'b11 : 2'b00;
    end
  endgenerate

  assign luse      = |op_lhit;
  assign mem_stall = mem_cache_en && !cache_ready;

  assign freeze_all  = mem_stall;
  assign stall_if_id = mem_stall || luse || (state_q != RUN);
  assign bubble_ex   = !mem_stall && (luse || (state_q != RUN));
  assign flush_if    = branch_taken && !stall_if_id;
  assign issue       = id_valid && !stall_if_id && !halt_dec;

  assign fwd1_sel   = op_sel[0];
  assign fwd2_sel   = op_sel[1];
  assign fwd_sv_sel = op_sel[2];

  assign has_reg1_hazard      = op_use[0] && ((op_sel[0] != 2'b00) || op_lhit[0]);
  assign has_reg2_hazard      = op_use[1] && ((op_sel[1] != 2'b00) || op_lhit[1]);
  assign has_saved_val_hazard = op_use[2] && ((op_sel[2] != 2'b00) || op_lhit[2]);

  assign halted_o  = halted_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    shadow_d = shadow_q;
    if (!mem_stall) begin
      shadow_d[WB]  = shadow_q[MEM];
      shadow_d[MEM] = shadow_q[EX];
      shadow_d[EX]  = issue ? {1'b1, dest_reg_num, reg_write, mem_to_reg} : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (halt_dec && id_valid && !stall_if_id) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd3;
        end
      end
      DRAIN: begin
        // Frozen cycles do not move the pipe, so they do not count toward the drain.
        if (!mem_stall) begin
          if (drain_cnt_q <= 2'd1) begin
            drain_cnt_d = 2'd0;
            state_d     = DONE;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  assign halted_d = (state_d == DONE);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_if_id || freeze_all) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: a cycle table of ID inputs with expected outputs,
// followed by halt, freeze-during-drain and reset sequences.
module tb_id_hazard_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         id_valid, is_reg1_valid, is_reg2_valid, is_SW_SB;
  logic [4:0]   reg1_num, reg2_num, dest_reg_num;
  logic         reg_write, mem_to_reg, halt_dec, branch_taken, mem_cache_en, cache_ready;
  logic         stall_if_id, bubble_ex, freeze_all, flush_if;
  logic         has_reg1_hazard, has_reg2_hazard, has_saved_val_hazard;
  logic [1:0]   fwd1_sel, fwd2_sel, fwd_sv_sel;
  logic         halted_o;
  logic [W-1:0] stall_cnt;

  id_hazard_ctrl #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .reg1_num(reg1_num), .reg2_num(reg2_num),
    .is_reg1_valid(is_reg1_valid), .is_reg2_valid(is_reg2_valid), .is_SW_SB(is_SW_SB),
    .dest_reg_num(dest_reg_num), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .halt_dec(halt_dec), .branch_taken(branch_taken),
    .mem_cache_en(mem_cache_en), .cache_ready(cache_ready),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .freeze_all(freeze_all),
    .flush_if(flush_if), .has_reg1_hazard(has_reg1_hazard), .has_reg2_hazard(has_reg2_hazard),
    .has_saved_val_hazard(has_saved_val_hazard), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .fwd_sv_sel(fwd_sv_sel), .halted_o(halted_o), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // want = {stall, bubble, freeze, flush, h1, h2, hsv, s1[1:0], s2[1:0], ssv[1:0], halted}
  typedef struct packed {
    logic        idv;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        v1;
    logic        v2;
    logic        sw;
    logic [4:0]  dst;
    logic        rw;
    logic        m2r;
    logic        halt;
    logic        br;
    logic        mce;
    logic        crdy;
    logic [13:0] want;
  } vec_t;

  typedef struct packed {
    logic [13:0]  outs;
    logic [W-1:0] cnt;
  } sb_t;

  vec_t         tbl[$];
  sb_t          sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_cnt = '0;

  function automatic vec_t ins(input logic idv, input logic [4:0] r1, input logic [4:0] r2,
                               input logic v1, input logic v2, input logic sw,
                               input logic [4:0] dst, input logic rw, input logic m2r);
    vec_t v;
    v = '0;
    v.idv = idv; v.r1 = r1; v.r2 = r2; v.v1 = v1; v.v2 = v2; v.sw = sw;
    v.dst = dst; v.rw = rw; v.m2r = m2r;
    return v;
  endfunction

  function automatic vec_t idle();
    return ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction
  function automatic vec_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return ins(1'b1, a, b, 1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0);
  endfunction
  function automatic vec_t lw(input logic [4:0] d, input logic [4:0] a);
    return ins(1'b1, a, 5'd0, 1'b1, 1'b0, 1'b0, d, 1'b1, 1'b1);
  endfunction
  function automatic vec_t sw(input logic [4:0] a, input logic [4:0] b);
    return ins(1'b1, a, b, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
  endfunction
  function automatic vec_t brn(input logic [4:0] a, input logic [4:0] b);
    vec_t v;
    v = ins(1'b1, a, b, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    v.br = 1'b1;
    return v;
  endfunction
  function automatic vec_t hlt();
    vec_t v;
    v = ins(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    v.halt = 1'b1;
    return v;
  endfunction
  function automatic vec_t wm(input vec_t vi, input logic crdy);
    vec_t v;
    v = vi; v.mce = 1'b1; v.crdy = crdy;
    return v;
  endfunction
  function automatic vec_t wb(input vec_t vi);
    vec_t v;
    v = vi; v.br = 1'b1;
    return v;
  endfunction

  function automatic logic [13:0] e(input logic st, input logic bu, input logic fr, input logic fl,
                                    input logic h1, input logic h2, input logic hs,
                                    input logic [1:0] s1, input logic [1:0] s2,
                                    input logic [1:0] ss, input logic ha);
    return {st, bu, fr, fl, h1, h2, hs, s1, s2, ss, ha};
  endfunction

  function automatic vec_t x(input vec_t vi, input logic [13:0] w);
    vec_t v;
    v = vi; v.want = w;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.idv; reg1_num = v.r1; reg2_num = v.r2;
    is_reg1_valid = v.v1; is_reg2_valid = v.v2; is_SW_SB = v.sw;
    dest_reg_num = v.dst; reg_write = v.rw; mem_to_reg = v.m2r;
    halt_dec = v.halt; branch_taken = v.br; mem_cache_en = v.mce; cache_ready = v.crdy;
  endtask

  function automatic logic [13:0] act_outs();
    return {stall_if_id, bubble_ex, freeze_all, flush_if,
            has_reg1_hazard, has_reg2_hazard, has_saved_val_hazard,
            fwd1_sel, fwd2_sel, fwd_sv_sel, halted_o};
  endfunction

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    sb_t s;
    @(negedge clk);
    drive(v);
    s.outs = v.want;
    s.cnt  = exp_cnt;
    sb_q.push_back(s);
    if (v.want[13] || v.want[11]) exp_cnt = exp_cnt + 1'b1;
    #1;
    s = sb_q.pop_front();
    checks++;
    if (act_outs() !== s.outs) begin
      errors++;
      $display("FAIL %s[%0d] outs got %b want %b", tag, idx, act_outs(), s.outs);
    end
    checks++;
    if (stall_cnt !== s.cnt) begin
      errors++;
      $display("FAIL %s[%0d] stall_cnt got %0d want %0d", tag, idx, stall_cnt, s.cnt);
    end
    $display("%s[%0d] outs=%b stall_cnt=%0d", tag, idx, act_outs(), stall_cnt);
  endtask

  // Reset is raised mid-cycle so its effect must be visible before any clock edge.
  task automatic reset_check(input string tag);
    @(negedge clk);
    drive(idle());
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act_outs() !== 14'b0) begin
      errors++;
      $display("FAIL %s reset outs got %b want %b", tag, act_outs(), 14'b0);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL %s reset stall_cnt got %0d want 0", tag, stall_cnt);
    end
    $display("%s reset outs=%b stall_cnt=%0d", tag, act_outs(), stall_cnt);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    logic [13:0] z, sbub, sfrz;
    z    = '0;
    sbub = e(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    sfrz = e(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);

    // ALU forwarding, load-use, $0 and store data, branches, priority, cache miss
    tbl.push_back(x(idle(),            z));
    tbl.push_back(x(alu(3, 1, 2),      z));
    tbl.push_back(x(alu(4, 3, 1),      e(0,0,0,0, 1,0,0, 2'b01,2'b00,2'b00, 0)));
    tbl.push_back(x(lw(5, 4),          e(0,0,0,0, 1,0,0, 2'b01,2'b00,2'b00, 0)));
    tbl.push_back(x(alu(6, 5, 5),      e(1,1,0,0, 1,1,0, 2'b00,2'b00,2'b00, 0)));
    tbl.push_back(x(alu(6, 5, 5),      e(0,0,0,0, 1,1,0, 2'b10,2'b10,2'b00, 0)));
    tbl.push_back(x(alu(0, 6, 6),      e(0,0,0,0, 1,1,0, 2'b01,2'b01,2'b00, 0)));
    tbl.push_back(x(sw(0, 0),          z));
    tbl.push_back(x(sw(0, 6),          e(0,0,0,0, 0,0,1, 2'b00,2'b00,2'b11, 0)));
    tbl.push_back(x(brn(0, 0),         e(0,0,0,1, 0,0,0, 2'b00,2'b00,2'b00, 0)));
    tbl.push_back(x(idle(),            z));
    tbl.push_back(x(lw(7, 0),          z));
    tbl.push_back(x(brn(7, 0),         e(1,1,0,0, 1,0,0, 2'b00,2'b00,2'b00, 0)));
    tbl.push_back(x(brn(7, 0),         e(0,0,0,1, 1,0,0, 2'b10,2'b00,2'b00, 0)));
    tbl.push_back(x(idle(),            z));
    tbl.push_back(x(alu(8, 1, 2),      z));
    tbl.push_back(x(alu(8, 1, 2),      z));
    tbl.push_back(x(alu(9, 8, 8),      e(0,0,0,0, 1,1,0, 2'b01,2'b01,2'b00, 0)));
    tbl.push_back(x(alu(10, 8, 9),     e(0,0,0,0, 1,1,0, 2'b10,2'b01,2'b00, 0)));
    tbl.push_back(x(ins(0, 10, 9, 1, 1, 0, 0, 0, 0), z));
    tbl.push_back(x(alu(11, 0, 0),     z));
    for (int i = 0; i < 4; i++)
      tbl.push_back(x(wm(alu(12, 11, 10), 1'b0), e(1,0,1,0, 1,1,0, 2'b01,2'b11,2'b00, 0)));
    tbl.push_back(x(wm(alu(12, 11, 10), 1'b1),   e(0,0,0,0, 1,1,0, 2'b01,2'b11,2'b00, 0)));
    tbl.push_back(x(lw(13, 12),        e(0,0,0,0, 1,0,0, 2'b01,2'b00,2'b00, 0)));
    tbl.push_back(x(wm(wb(alu(14, 13, 11)), 1'b0), e(1,0,1,0, 1,1,0, 2'b00,2'b11,2'b00, 0)));
    tbl.push_back(x(wm(wb(alu(14, 13, 11)), 1'b1), e(1,1,0,0, 1,1,0, 2'b00,2'b11,2'b00, 0)));
    tbl.push_back(x(wb(alu(14, 13, 11)), e(0,0,0,1, 1,0,0, 2'b10,2'b00,2'b00, 0)));
    tbl.push_back(x(idle(),            z));

    drive(idle());
    reset_check("init");
    foreach (tbl[i]) run_vec("tbl", i, tbl[i]);

    // Plain halt: three drain cycles, then halted; reset clears it at once.
    run_vec("halt", 0, x(hlt(), z));
    for (int i = 1; i <= 3; i++) run_vec("halt", i, x(idle(), sbub));
    run_vec("halt", 4, x(idle(), e(1,1,0,0, 0,0,0, 2'b00,2'b00,2'b00, 1)));
    reset_check("done");

    // Halt with a two-cycle freeze in the middle of the drain.
    run_vec("hfrz", 0, x(hlt(), z));
    run_vec("hfrz", 1, x(idle(), sbub));
    run_vec("hfrz", 2, x(wm(idle(), 1'b0), sfrz));
    run_vec("hfrz", 3, x(wm(idle(), 1'b0), sfrz));
    run_vec("hfrz", 4, x(wm(idle(), 1'b1), sbub));
    run_vec("hfrz", 5, x(idle(), sbub));
    run_vec("hfrz", 6, x(idle(), e(1,1,0,0, 0,0,0, 2'b00,2'b00,2'b00, 1)));
    reset_check("hfrz");

    // Reset while draining, then normal issue and forwarding again.
    run_vec("hrst", 0, x(hlt(), z));
    run_vec("hrst", 1, x(idle(), sbub));
    reset_check("drain");
    run_vec("hrst", 2, x(alu(15, 1, 2), z));
    run_vec("hrst", 3, x(alu(16, 15, 0), e(0,0,0,0, 1,0,0, 2'b01,2'b00,2'b00, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
